// File: rtl/dn_return_channel.sv
// L2-to-L1 downgrade channel: a small FIFO written by the owning domain,
// drained only on a fixed epoch tick under a trusted L1 release permission.
module dn_return_channel #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EPOCH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dom,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_full,
  input  logic             declass_ok,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             tick
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = $clog2(EPOCH);

  logic [EW-1:0]    epoch_cnt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             dom_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic scrub;
  logic pop;
  logic push;

  // Schedule and occupancy views depend only on registered state.
  assign tick    = (epoch_cnt == EW'(EPOCH - 1));
  assign wr_full = (count == CW'(DEPTH));

  // A pop frees the head slot, so a push into a full FIFO is legal on a pop edge.
  assign scrub = (dom != dom_q);
  assign pop   = tick & declass_ok & (count != '0) & ~scrub;
  assign push  = wr_en & ~scrub & (~wr_full | pop);

  // Free-running epoch counter; never disturbed by scrubs or writer activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt <= '0;
    end else if (epoch_cnt == EW'(EPOCH - 1)) begin
      epoch_cnt <= '0;
    end else begin
      epoch_cnt <= epoch_cnt + EW'(1);
    end
  end

  // FIFO state, ownership tracking and the L1-facing release register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dom_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (scrub) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dom_q    <= dom;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dn_return_channel.sv
// Directed self-checking bench for dn_return_channel: reset, ordering, full,
// permission gating, domain scrub and simultaneous push/pop.
module tb_dn_return_channel;

  logic       clk;
  logic       rst_n;
  logic       dom;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       wr_full;
  logic       declass_ok;
  logic       rd_valid;
  logic [1:0] rd_data;
  logic       tick;

  int checks;
  int errors;

  dn_return_channel #(.WIDTH(2), .DEPTH(4), .EPOCH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dom        (dom),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .declass_ok (declass_ok),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return at the negedge where tick is high; the next posedge is a tick edge.
  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL wait_tick: observed no tick expected tick within 20 cycles");
    end
  endtask

  task automatic write_word(input logic [1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Pass the next tick edge and check the release register one cycle later.
  task automatic expect_release(input string tag, input logic v, input logic [1:0] d);
    wait_tick();
    step();
    check({tag, "_valid"}, 32'(rd_valid), 32'(v));
    check({tag, "_data"}, 32'(rd_data), 32'(d));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    dom        = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 2'b00;
    declass_ok = 1'b0;
    #3;
    check("reset_valid", 32'(rd_valid), 32'(0));
    check("reset_full", 32'(wr_full), 32'(0));
    check("reset_tick", 32'(tick), 32'(0));

    // Reset mid-operation after three writes
    step();
    rst_n = 1'b1;
    write_word(2'b01);
    write_word(2'b10);
    write_word(2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rd_valid), 32'(0));
    check("midrst_data", 32'(rd_data), 32'(0));
    check("midrst_full", 32'(wr_full), 32'(0));
    check("midrst_tick", 32'(tick), 32'(0));
    step();
    rst_n      = 1'b1;
    declass_ok = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("first_tick_early", 32'(tick), 32'(0));
    step();
    check("first_tick_7", 32'(tick), 32'(1));
    step();
    check("empty_after_reset", 32'(rd_valid), 32'(0));

    // Ordered release from domain 1
    dom = 1'b1;
    step();
    write_word(2'b01);
    write_word(2'b10);
    write_word(2'b11);
    expect_release("ord0", 1'b1, 2'b01);
    step();
    check("ord0_hold_valid", 32'(rd_valid), 32'(0));
    check("ord0_hold_data", 32'(rd_data), 32'(1));
    expect_release("ord1", 1'b1, 2'b10);
    expect_release("ord2", 1'b1, 2'b11);

    // Full FIFO drops the fifth word
    write_word(2'd0);
    write_word(2'd1);
    write_word(2'd2);
    check("full_after3", 32'(wr_full), 32'(0));
    write_word(2'd3);
    check("full_after4", 32'(wr_full), 32'(1));
    write_word(2'd0);
    check("full_after5", 32'(wr_full), 32'(1));
    expect_release("full0", 1'b1, 2'd0);
    check("full_cleared", 32'(wr_full), 32'(0));
    expect_release("full1", 1'b1, 2'd1);
    expect_release("full2", 1'b1, 2'd2);
    expect_release("full3", 1'b1, 2'd3);
    expect_release("full_drop", 1'b0, 2'd3);

    // Permission gating
    declass_ok = 1'b0;
    write_word(2'b10);
    expect_release("gate0", 1'b0, 2'd3);
    expect_release("gate1", 1'b0, 2'd3);
    declass_ok = 1'b1;
    step();
    check("gate_wait", 32'(rd_valid), 32'(0));
    expect_release("gate_open", 1'b1, 2'b10);

    // Domain scrub with a write on the toggle edge
    write_word(2'b01);
    write_word(2'b11);
    dom     = 1'b0;
    wr_en   = 1'b1;
    wr_data = 2'b10;
    step();
    wr_en = 1'b0;
    check("scrub_data", 32'(rd_data), 32'(0));
    check("scrub_full", 32'(wr_full), 32'(0));
    expect_release("scrub_tick", 1'b0, 2'b00);
    dom     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 2'b01;
    step();
    wr_data = 2'b10;
    step();
    wr_en = 1'b0;
    expect_release("post_scrub", 1'b1, 2'b10);
    expect_release("post_scrub_empty", 1'b0, 2'b10);

    // Simultaneous push and pop on a full FIFO
    declass_ok = 1'b0;
    write_word(2'b01);
    write_word(2'b10);
    write_word(2'b11);
    write_word(2'b00);
    check("sim_full", 32'(wr_full), 32'(1));
    declass_ok = 1'b1;
    wait_tick();
    wr_en   = 1'b1;
    wr_data = 2'b11;
    step();
    wr_en = 1'b0;
    check("sim_valid", 32'(rd_valid), 32'(1));
    check("sim_data", 32'(rd_data), 32'(1));
    check("sim_still_full", 32'(wr_full), 32'(1));
    expect_release("sim1", 1'b1, 2'b10);
    expect_release("sim2", 1'b1, 2'b11);
    expect_release("sim3", 1'b1, 2'b00);
    expect_release("sim4", 1'b1, 2'b11);
    expect_release("sim_empty", 1'b0, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
